// File: rtl/div_unit.sv
// Purpose : multi-cycle restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Latency : 32 cycles from the accepting edge (1 cycle for divide-by-zero); result and ready registered.
// Backpressure: stallreq holds upstream while a request is pending; the result is held while start stays high.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start_i       - request, held until ready_o is seen
//   signed_div_i  - 1 = two's-complement divide, 0 = unsigned (sampled in IDLE)
//   annul_i       - abort an in-flight division, or block a start in IDLE
//   opdata1_i/2_i - dividend / divisor (sampled in IDLE)
//   result_o      - {remainder, quotient}
//   ready_o       - result valid
//   stallreq_o    - start_i & ~ready_o
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;     // partial remainder
    logic [WIDTH-1:0] quo;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dsr;     // divisor magnitude
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign stallreq_o = start_i & ~ready_o;

    always_comb begin
        a_abs    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_abs    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

        // One restoring step: the 33-bit shifted remainder can exceed the divisor
        // range, and the borrow out of the trial subtraction decides the quotient bit.
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, dsr};
        qbit     = ~trial[WIDTH];
        rem_next = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], qbit};

        // Quotient negative when signs differ; remainder follows the dividend.
        q_fix    = neg_q ? -quo_next : quo_next;
        r_fix    = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        rem   <= '0;
                        quo   <= a_abs;
                        dsr   <= b_abs;
                        neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                        cnt   <= '0;
                        state <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end
                end

                S_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= S_END;
                end

                S_ON: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            result_o <= {r_fix, q_fix};
                            ready_o  <= 1'b1;
                            state    <= S_END;
                        end
                    end
                end

                S_END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Purpose : self-checking bench for div_unit with directed and randomized divisions.
// Latency : expects 32 edges per division, 1 for divide-by-zero.
// Backpressure: holds start until ready, then drops it for one cycle between divisions.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .signed_div_i(sgn),
        .annul_i     (annul),
        .opdata1_i   (a),
        .opdata2_i   (b),
        .result_o    (result),
        .ready_o     (ready),
        .stallreq_o  (stallreq)
    );

    // Reference: plain integer arithmetic; SV division truncates toward zero and
    // the remainder takes the dividend's sign, which is exactly DIV semantics.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint lx, ly, lq, lr;
        logic [63:0] tq, tr;
        if (y == 32'd0) return 64'd0;
        if (s) begin
            lx = longint'($signed(x));
            ly = longint'($signed(y));
        end else begin
            lx = longint'({32'd0, x});
            ly = longint'({32'd0, y});
        end
        lq = lx / ly;
        lr = lx % ly;
        tq = lq;
        tr = lr;
        return {tr[31:0], tq[31:0]};
    endfunction

    // Run one division from IDLE; optional hold cycles in END and operand scrambling while busy.
    task automatic do_div(input string name, input logic [31:0] da, input logic [31:0] db,
                          input logic ds, input logic [63:0] exp, input int hold, input bit scramble);
        int edges;
        bit seen;
        int exp_lat;
        exp_lat = (db == 32'd0) ? 1 : 32;
        a = da; b = db; sgn = ds; annul = 1'b0; start = 1'b1;
        #1;
        n_checks++;
        if (stallreq !== 1'b1) begin
            n_errors++;
            $display("FAIL %s stall_at_start: got %b expected 1", name, stallreq);
        end
        @(posedge clk); #1;   // E0
        seen = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (scramble) begin
                a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            edges = i;
            if (ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                n_checks++;
                if (stallreq !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s stall_busy: got %b expected 1 at edge %0d", name, stallreq, i);
                end
            end
        end
        n_checks++;
        if (!seen || edges != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d (ready seen %0b) expected %0d", name, edges, seen, exp_lat);
        end
        n_checks++;
        if (result !== exp) begin
            n_errors++;
            $display("FAIL %s result: got %h expected %h", name, result, exp);
        end
        n_checks++;
        if (stallreq !== 1'b0) begin
            n_errors++;
            $display("FAIL %s stall_at_ready: got %b expected 0", name, stallreq);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready !== 1'b1 || result !== exp) begin
                n_errors++;
                $display("FAIL %s hold%0d: got ready=%b result=%h expected ready=1 result=%h", name, h, ready, result, exp);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_errors++;
            $display("FAIL %s release: got ready=%b result=%h expected ready=0 result=0", name, ready, result);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; annul = 1'b0; sgn = 1'b0; a = 32'd9; b = 32'd3;
        repeat (3) @(posedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got ready=%b result=%h stall=%b expected 0/0/0", ready, result, stallreq);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 0, 1'b0);
        do_div("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 0, 1'b0);
        do_div("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 0, 1'b0);
        do_div("udiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 0, 1'b0);
    endtask

    task automatic test_div_zero();
        do_div("udiv_by_zero", 32'd5, 32'd0, 1'b0, 64'd0, 0, 1'b0);
        do_div("sdiv_by_zero", 32'd5, 32'd0, 1'b1, 64'd0, 0, 1'b0);
    endtask

    task automatic test_annul();
        bit saw_ready;
        a = 32'h12345678; b = 32'd3; sgn = 1'b0; start = 1'b1; annul = 1'b0;
        @(posedge clk);             // E0
        repeat (9) @(posedge clk);  // E9
        #1 annul = 1'b1;
        @(posedge clk); #1;         // E10
        annul = 1'b0; start = 1'b0;
        saw_ready = (ready === 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) saw_ready = 1'b1;
        end
        n_checks++;
        if (saw_ready) begin
            n_errors++;
            $display("FAIL annul_no_ready: got ready=1 expected ready to stay 0");
        end
        do_div("after_annul", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        // Reset in END clears a held nonzero result.
        a = 32'd100; b = 32'd7; sgn = 1'b0; start = 1'b1; annul = 1'b0;
        repeat (34) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_in_end: got ready=%b result=%h expected 0/0", ready, result);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        // Reset at E5 during ON.
        a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);             // E0
        repeat (4) @(posedge clk);  // E4
        #1 rst = 1'b1;
        @(posedge clk); #1;         // E5
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_mid_div: got ready=%b result=%h expected 0/0", ready, result);
        end
        rst = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abandons_div: got ready=%b expected 0", ready);
        end
        do_div("sdiv_overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0, 1'b0);
    endtask

    task automatic test_hold_and_scramble();
        do_div("hold_end", 32'hDEADBEEF, 32'd1234, 1'b0, ref_div(32'hDEADBEEF, 32'd1234, 1'b0), 3, 1'b0);
        do_div("scramble_ops", 32'hF0000001, 32'd77, 1'b1, ref_div(32'hF0000001, 32'd77, 1'b1), 0, 1'b1);
        do_div("scramble_zero", 32'd42, 32'd0, 1'b1, 64'd0, 2, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic        s;
        for (int n = 0; n < 40; n++) begin
            x = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1, 2:    y = $urandom_range(1, 15);
                3:       y = -($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                x = 32'h80000000;
                y = 32'hFFFFFFFF;
            end
            do_div("random", x, y, s, ref_div(x, y, s), n % 3, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_hold_and_scramble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider in the EX stage for DIV/DIVU. It consumes operands delivered by the ID/EX pipeline register and produces a 64-bit {remainder, quotient} result for HI/LO. While a division is in flight, it drives a stall request back toward ID/EX and earlier stages, holding them in place until the result is ready. One quotient bit is produced per cycle (restoring algorithm), so a division takes 32 cycles; divide-by-zero finishes early.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request from EX; held high by EX until `ready_o` is seen.
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i` in IDLE.
- annul_i  input  1  abort the current division (branch-delay cancel / flush).
- opdata1_i  input  WIDTH  dividend; sampled in IDLE.
- opdata2_i  input  WIDTH  divisor; sampled in IDLE.
- result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result valid; registered.
- stallreq_o  output  1  combinational: `start_i & ~ready_o`.

## Operation
- States: IDLE, BYZERO, ON, END.
- Reset (`rst`=1 at an edge) forces:
  - state IDLE, counter 0.
  - `result_o`=0, `ready_o`=0.
  - Takes priority over every other input, including mid-division.
- IDLE:
  - `start_i`=1, `annul_i`=0, divisor=0 → BYZERO.
  - `start_i`=1, `annul_i`=0, divisor≠0 → ON, cnt=0.
  - Latch operands. When signed, latch absolute values plus both sign bits.
  - Otherwise remain in IDLE.
- BYZERO:
  - Next edge → END, `result_o`=0, `ready_o`=1.
- ON:
  - Each edge performs one restoring step on a 33-bit partial remainder, shifting in one dividend bit and producing one quotient bit. cnt increments.
  - On the step with cnt=31 (the 32nd step) → END.
    - Load `result_o` with the sign-corrected result and set `ready_o`=1.
    - Quotient is negated iff signed and the operand signs differ.
    - Remainder takes the sign of the dividend.
  - `annul_i`=1 at any ON edge → IDLE. The step is discarded and `ready_o` stays 0.
- END:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - `start_i`=0 → IDLE, `result_o`=0, `ready_o`=0.
- Arithmetic:
  - Magnitudes are computed as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000 is correct.
  - Overflow case 0x80000000 / -1 (signed) yields q=0x80000000, r=0. No trap is raised.
- `annul_i` in IDLE blocks a start. `annul_i` in BYZERO and END is ignored.
- `signed_div_i` and operand changes after leaving IDLE are ignored.

## Timing
- Let E0 be the edge at which `start_i` is sampled in IDLE.
- Normal path:
  - ON during E1..E32.
  - `ready_o`=1 and `result_o` valid after E32, i.e. latency 32 cycles from E0.
- Divide-by-zero: `ready_o`=1 after E1.
- `stallreq_o`:
  - Is 1 from the cycle `start_i` rises until `ready_o` rises, combinationally.
  - Drops in the same cycle `ready_o` goes high.
  - Upstream (ID/EX) advances on the next edge.
- Back-to-back divides:
  - EX must drop `start_i` for at least one cycle. END→IDLE takes one edge.
  - A new start is accepted at the following edge.
- After `annul_i`:
  - IDLE at the next edge.
  - A new start is accepted one edge later.

## Test plan
- Unsigned 100/7, start at E0 → `ready_o` rises after E32, `result_o`=0x00000002_0000000E, `stallreq_o`=1 for cycles E0..E31.
- Signed 0xFFFFFFF9 (-7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7 / 0xFFFFFFFE (-2) → q=0xFFFFFFFD, r=0x00000001.
- Divide by zero (5/0, both modes) → `ready_o`=1 after E1, `result_o`=0. Drop `start_i` → `ready_o`=0 and `result_o`=0 after the next edge.
- `annul_i` pulsed at E10 during ON → state IDLE after E10, `ready_o` never asserts. A new start 0xFFFFFFFF/1 unsigned then completes normally with q=0xFFFFFFFF, r=0.
- `rst` asserted at E5 mid-division → all outputs 0 after E5. A subsequent signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0 after 32 cycles.
- Hold `start_i` 3 extra cycles in END → `result_o` stable and `ready_o` high throughout. Vary operands during ON → result unaffected.
